// File: rtl/drum_audio_out.sv
// drum_audio_out
// Audio output stage behind the drum-node column simulator. Buffers one
// signed 1.17 sample per time step in a small FIFO. Each popped sample gets
// the fixed GAIN shift and is saturated to 18 bits. The result is sent to the
// codec as a left write followed by a right write, using a ready/write
// handshake.
//
// Ports
//   clk_50            system clock, rising edge
//   reset             synchronous, active-low
//   sample_in         signed 1.17 drum sample
//   sample_valid      one-cycle strobe qualifying sample_in
//   sample_ready      FIFO not full
//   audio_data        32-bit codec word, held for both channel writes
//   audio_left_write  left-channel write request
//   audio_right_write right-channel write request
//   audio_ready       codec can accept a write this edge
//   fifo_count        FIFO occupancy
//   overflow          sticky, a sample was dropped
//   samples_sent      completed L+R pairs (wraps)
module drum_audio_out #(
  parameter int DEPTH = 16,
  parameter int GAIN  = 6
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic [17:0]              sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic [31:0]              audio_data,
  output logic                     audio_left_write,
  output logic                     audio_right_write,
  input  logic                     audio_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [31:0]              samples_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = 18 + GAIN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [17:0]          mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [1:0]           state_q, state_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          sent_q, sent_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop;
  logic signed [XW-1:0] x_ext, x_sh;
  logic [GAIN:0]        x_top;
  logic [17:0]          sat;

  always_comb begin
    sample_ready = (count_q != CW'(DEPTH));
    push         = sample_valid & sample_ready;
    pop          = (state_q == ST_IDLE) && (count_q != '0);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // A drop is judged against the pre-edge count, so a push into a full
    // FIFO is lost even when a pop happens on the same edge.
    ovf_d = ovf_q | (sample_valid & ~sample_ready);

    // Gain and saturation. The bits above bit 17 must all match the sign
    // bit, otherwise the value does not fit in 18 bits and is clamped.
    x_ext = XW'($signed(mem_q[rd_ptr_q]));
    x_sh  = x_ext <<< GAIN;
    x_top = x_sh[XW-1:17];
    if (x_top == '0 || x_top == '1) sat = x_sh[17:0];
    else if (x_sh[XW-1])            sat = 18'h20000;
    else                            sat = 18'h1FFFF;

    data_d  = pop ? {sat, 14'b0} : data_q;
    sent_d  = sent_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_LEFT;
      ST_LEFT:  if (audio_ready) state_d = ST_RIGHT;
      ST_RIGHT: if (audio_ready) begin
        state_d = ST_IDLE;
        sent_d  = sent_q + 32'd1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      data_q   <= '0;
      sent_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      data_q   <= data_d;
      sent_q   <= sent_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk_50) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  assign audio_data        = data_q;
  assign audio_left_write  = (state_q == ST_LEFT);
  assign audio_right_write = (state_q == ST_RIGHT);
  assign fifo_count        = count_q;
  assign overflow          = ovf_q;
  assign samples_sent      = sent_q;

endmodule

// File: tb/tb_drum_audio_out.sv
`timescale 1ns/1ps
module tb_drum_audio_out;
  localparam int DEPTH = 16;
  localparam int GAIN  = 6;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b0;
  logic [17:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [31:0] audio_data;
  logic        audio_left_write, audio_right_write;
  logic        audio_ready = 1'b1;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [31:0] samples_sent;

  drum_audio_out #(.DEPTH(DEPTH), .GAIN(GAIN)) dut (
    .clk_50(clk_50), .reset(reset), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .audio_data(audio_data), .audio_left_write(audio_left_write),
    .audio_right_write(audio_right_write), .audio_ready(audio_ready),
    .fifo_count(fifo_count), .overflow(overflow), .samples_sent(samples_sent)
  );

  always #10 clk_50 = ~clk_50;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_sent = '0;
  logic        left_done = 0, prev_left = 0, prev_right = 0, prev_ready = 0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [17:0] s);
    longint v;
    v = longint'($signed(s)) * (longint'(1) << GAIN);
    if (v > 131071)       v = 131071;
    else if (v < -131072) v = -131072;
    return {v[17:0], 14'b0};
  endfunction

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic push(input logic [17:0] s, input bit acc);
    sample_in    = s;
    sample_valid = 1'b1;
    if (acc) sb.push_back(conv(s));
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  // Codec-side monitor: inputs settle #1 after posedge, so the negedge view
  // is exactly what the next rising edge will act on.
  always @(negedge clk_50) begin
    if (!reset) begin
      exp_sent   = '0;
      left_done  = 0;
      prev_left  = 0;
      prev_right = 0;
      prev_ready = 0;
    end else begin
      chk("samples_sent", samples_sent, exp_sent);
      chk("strobe_excl", {31'b0, audio_left_write & audio_right_write}, 0);
      if (prev_left && !prev_ready) begin
        chk("hold_left", {31'b0, audio_left_write}, 1);
        chk("hold_data", audio_data, prev_data);
      end
      if (prev_right && !prev_ready) chk("hold_right", {31'b0, audio_right_write}, 1);
      if (audio_right_write) chk("r_after_l", {31'b0, left_done}, 1);
      if (audio_left_write && audio_ready) begin
        if (sb.size() == 0) chk("sb_underrun_l", 0, 1);
        else chk("left_data", audio_data, sb[0]);
        left_done = 1;
      end
      if (audio_right_write && audio_ready) begin
        if (sb.size() == 0) chk("sb_underrun_r", 0, 1);
        else chk("right_data", audio_data, sb.pop_front());
        left_done = 0;
        exp_sent  = exp_sent + 1;
      end
      prev_left  = audio_left_write;
      prev_right = audio_right_write;
      prev_ready = audio_ready;
      prev_data  = audio_data;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [17:0] first;
    tick(); tick(); tick();
    chk("rst_data", audio_data, 0);
    chk("rst_left", {31'b0, audio_left_write}, 0);
    chk("rst_right", {31'b0, audio_right_write}, 0);
    chk("rst_count", {27'b0, fifo_count}, 0);
    chk("rst_ready", {31'b0, sample_ready}, 1);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_sent", samples_sent, 0);
    reset = 1'b1;
    tick();

    // Basic path and latency
    audio_ready = 1'b1;
    push(18'h00100, 1);
    chk("lat_e_left", {31'b0, audio_left_write}, 0);
    chk("lat_e_count", {27'b0, fifo_count}, 1);
    tick();
    chk("lat_e1_left", {31'b0, audio_left_write}, 1);
    chk("lat_e1_data", audio_data, 32'h10000000);
    tick();
    chk("lat_e2_right", {31'b0, audio_right_write}, 1);
    chk("lat_e2_left", {31'b0, audio_left_write}, 0);
    tick();
    chk("lat_e3_right", {31'b0, audio_right_write}, 0);
    chk("lat_e3_sent", samples_sent, 1);
    tick();

    // Negative and saturating values
    push(18'h3FF00, 1); tick();
    chk("neg_data", audio_data, 32'hF0000000);
    tick(); tick(); tick();
    push(18'h01000, 1); tick();
    chk("satp_data", audio_data, 32'h7FFFC000);
    tick(); tick(); tick();
    push(18'h3F000, 1); tick();
    chk("satn_data", audio_data, 32'h80000000);
    drain();

    // Backpressure and overflow
    audio_ready = 1'b0;
    first = 18'h00123;
    push(first, 1);
    for (int i = 1; i < 17; i++) push(18'(i * 18'h00321), 1);
    chk("bp_count", {27'b0, fifo_count}, 16);
    chk("bp_ready", {31'b0, sample_ready}, 0);
    chk("bp_left", {31'b0, audio_left_write}, 1);
    chk("bp_data", audio_data, conv(first));
    chk("bp_ovf0", {31'b0, overflow}, 0);
    push(18'h2AAAA, 0);
    chk("bp_ovf1", {31'b0, overflow}, 1);
    chk("bp_count2", {27'b0, fifo_count}, 16);
    audio_ready = 1'b1;
    drain();
    chk("bp_ovf_sticky", {31'b0, overflow}, 1);
    chk("bp_sent", samples_sent, 21);

    // Simultaneous push and pop at count 3 in IDLE
    audio_ready = 1'b0;
    push(18'h00011, 1); push(18'h00022, 1); push(18'h00033, 1); push(18'h00044, 1);
    chk("sim_count_pre", {27'b0, fifo_count}, 3);
    audio_ready = 1'b1;
    tick(); tick();
    audio_ready = 1'b0;
    chk("sim_idle", {30'b0, audio_left_write, audio_right_write}, 0);
    push(18'h00055, 1);
    chk("sim_count", {27'b0, fifo_count}, 3);
    audio_ready = 1'b1;
    drain();

    // Pointer wrap: 40 samples in bursts
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push(18'($urandom), 1);
      drain();
    end

    // Handshake stall with toggling ready
    for (int i = 0; i < 90; i++) begin
      audio_ready  = i[0];
      sample_valid = (i % 9 == 0);
      sample_in    = 18'($urandom);
      if (sample_valid) sb.push_back(conv(sample_in));
      tick();
    end
    sample_valid = 1'b0;
    audio_ready  = 1'b1;
    drain();

    // Reset while in LEFT with 5 queued
    audio_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(18'(18'h01111 * (i + 1)), 1);
    chk("mr_count_pre", {27'b0, fifo_count}, 5);
    chk("mr_left_pre", {31'b0, audio_left_write}, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    chk("mr_count", {27'b0, fifo_count}, 0);
    chk("mr_left", {31'b0, audio_left_write}, 0);
    chk("mr_right", {31'b0, audio_right_write}, 0);
    chk("mr_sent", samples_sent, 0);
    chk("mr_ovf", {31'b0, overflow}, 0);
    chk("mr_data", audio_data, 0);
    audio_ready = 1'b1;
    push(18'h1FFFF, 1);
    drain();
    chk("post_sent", samples_sent, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
